// File: rtl/instr_mem_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory arbiter slice.
package instr_mem_arbiter_pkg;

    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_ADDR_WIDTH      = 8;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_MAX_OUTSTANDING = 4;

    // Width of a requester index (tag); never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tag type carried through the in-order response FIFO.
    typedef logic [idx_width(DEF_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Bundles the requester-side and memory-side handshakes of the arbiter.
// slave: the arbiter's view; master: the view of the CU array plus memory.
interface instr_mem_arbiter_if
    import instr_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          mem_req_valid;
    logic [ADDR_WIDTH-1:0]         mem_req_addr;
    logic                          mem_req_ready;
    logic                          mem_resp_valid;
    logic [DATA_WIDTH-1:0]         mem_resp_data;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/instr_mem_arbiter_tag_fifo.sv
// Synchronous FIFO of requester tags. Pointers carry one extra bit so that
// full and empty are told apart by the pointer difference. A push on a full
// FIFO is accepted only when a pop happens in the same cycle.
module arb_tag_fifo
    import instr_mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [0:(1 << AW)-1];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [AW:0]      diff_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy, status flags and head-of-queue read.
    always_comb begin
        diff_s    = wr_q - rd_q;
        full_o    = (diff_s == (AW+1)'(DEPTH));
        empty_o   = (diff_s == '0);
        count_o   = CW'(diff_s);
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
        dout_o    = mem_q[rd_q[AW-1:0]];
    end

    // Pointer and storage update; reset forgets every stored tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < (1 << AW); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instr_mem_arbiter.sv
// Shares one instruction-memory read port between NUM_REQ fetch requesters.
// Round-robin grant, zero-latency request path, and an in-order tag FIFO
// that steers each memory response back to the requester that issued it.
module instr_mem_arbiter
    import instr_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    instr_mem_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]    outstanding_o,
    output logic                protocol_error_o
);

    localparam int IW = idx_width(NUM_REQ);

    logic [IW-1:0]         rr_q;
    logic [IW-1:0]         rr_d;
    logic [IW:0]           cand_s;
    logic                  gnt_found_s;
    logic [IW-1:0]         gnt_idx_s;
    logic [ADDR_WIDTH-1:0] gnt_addr_s;
    logic                  can_issue_s;
    logic                  issue_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [IW-1:0]         fifo_dout_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic [NUM_REQ-1:0]    resp_valid_s;
    logic                  protocol_error_q;
    logic                  protocol_error_d;

    // Rotating-priority search: first valid requester at or after rr_q.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, rr_q} + (IW+1)'(i);
            if (cand_s >= (IW+1)'(NUM_REQ)) begin
                cand_s = cand_s - (IW+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_found_s && bus.req_valid[cand_s[IW-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s[IW-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Address mux for the granted requester.
    always_comb begin
        gnt_addr_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx_s == IW'(k)) begin
                gnt_addr_s = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                gnt_addr_s = gnt_addr_s;
            end
        end
    end

    // Issue/pop decisions; a full FIFO may still accept when it pops this cycle.
    always_comb begin
        can_issue_s      = !fifo_full_s || bus.mem_resp_valid;
        issue_s          = gnt_found_s && can_issue_s && bus.mem_req_ready;
        pop_s            = bus.mem_resp_valid && !fifo_empty_s;
        protocol_error_d = protocol_error_q || (bus.mem_resp_valid && fifo_empty_s);
        if (issue_s) begin
            rr_d = (gnt_idx_s == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_s + IW'(1);
        end else begin
            rr_d = rr_q;
        end
    end

    // One-hot accept and response strobes.
    always_comb begin
        req_ready_s  = '0;
        resp_valid_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready_s[k]  = issue_s && (gnt_idx_s == IW'(k));
            resp_valid_s[k] = pop_s && (fifo_dout_s == IW'(k));
        end
    end

    // Round-robin pointer and sticky protocol-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q             <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            rr_q             <= rr_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    arb_tag_fifo #(
        .WIDTH (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue_s),
        .pop_i   (pop_s),
        .din_i   (gnt_idx_s),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign bus.mem_req_valid = gnt_found_s && can_issue_s;
    assign bus.mem_req_addr  = gnt_addr_s;
    assign bus.req_ready     = req_ready_s;
    assign bus.resp_valid    = resp_valid_s;
    assign bus.resp_data     = bus.mem_resp_data;
    assign outstanding_o     = fifo_count_s;
    assign protocol_error_o  = protocol_error_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_instr_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] outstanding;
    logic       protocol_error;
    int         checks = 0;
    int         errors = 0;

    instr_mem_arbiter_if bus ();

    instr_mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .outstanding_o    (outstanding),
        .protocol_error_o (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req_valid      = 4'b0000;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req_addr      = 32'h0;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", protocol_error); end
        checks++; if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_strobes: ready %b resp %b expected 0000 0000", bus.req_ready, bus.resp_valid); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_memreq: got %b expected 0", bus.mem_req_valid); end
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        bus.req_valid     = 4'b0100;
        bus.req_addr      = {8'hA3, 8'h10, 8'hA1, 8'hA0};
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 8'h10) begin errors++; $display("FAIL single_addr: got v%b %h expected v1 10", bus.mem_req_valid, bus.mem_req_addr); end
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outst: got %0d expected 1", outstanding); end
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hC0DE0010;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 4'b0100) begin errors++; $display("FAIL single_resp: got %b expected 0100", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'hC0DE0010) begin errors++; $display("FAIL single_data: got %h expected c0de0010", bus.resp_data); end
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (outstanding !== 3'd0 || bus.resp_valid !== 4'b0000) begin errors++; $display("FAIL single_drain: got %0d %b expected 0 0000", outstanding, bus.resp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_v;
        do_reset();
        bus.req_addr      = {8'h23, 8'h22, 8'h21, 8'h20};
        bus.mem_req_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk); #1;
            bus.req_valid      = (c < 8) ? 4'b1111 : 4'b0000;
            bus.mem_resp_valid = (c > 0);
            bus.mem_resp_data  = 32'h1000 + 32'(c - 1);
            @(negedge clk);
            if (c < 8) begin
                exp_v = 4'(1 << (c % 4));
                checks++; if (bus.req_ready !== exp_v) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, bus.req_ready, exp_v); end
                checks++; if (bus.mem_req_addr !== 8'(8'h20 + c % 4)) begin errors++; $display("FAIL rr_addr c%0d: got %h expected %h", c, bus.mem_req_addr, 8'(8'h20 + c % 4)); end
            end
            if (c > 0) begin
                exp_v = 4'(1 << ((c - 1) % 4));
                checks++; if (bus.resp_valid !== exp_v) begin errors++; $display("FAIL rr_resp c%0d: got %b expected %b", c, bus.resp_valid, exp_v); end
                checks++; if (bus.resp_data !== 32'h1000 + 32'(c - 1)) begin errors++; $display("FAIL rr_data c%0d: got %h expected %h", c, bus.resp_data, 32'h1000 + 32'(c - 1)); end
                checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL rr_outst c%0d: got %0d expected 1", c, outstanding); end
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rr_final_outst: got %0d expected 0", outstanding); end
    endtask

    task automatic test_stall_full();
        logic [3:0] exp_v;
        do_reset();
        bus.req_addr      = {8'h33, 8'h32, 8'h31, 8'h30};
        bus.mem_req_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus.req_valid = 4'b1111;
            @(negedge clk);
            exp_v = (c < 4) ? 4'(1 << c) : 4'b0000;
            checks++; if (bus.req_ready !== exp_v) begin errors++; $display("FAIL full_grant c%0d: got %b expected %b", c, bus.req_ready, exp_v); end
            checks++; if (outstanding !== 3'((c < 4) ? c : 4)) begin errors++; $display("FAIL full_outst c%0d: got %0d expected %0d", c, outstanding, (c < 4) ? c : 4); end
        end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_memreq: got %b expected 0", bus.mem_req_valid); end
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h000000D0;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 4'b0001) begin errors++; $display("FAIL free_resp: got %b expected 0001", bus.resp_valid); end
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL free_grant: got %b expected 0001", bus.req_ready); end
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0000 || outstanding !== 3'd4) begin errors++; $display("FAIL free_once: got %b %0d expected 0000 4", bus.req_ready, outstanding); end
    endtask

    task automatic test_full_push_pop();
        @(posedge clk); #1;
        bus.req_valid      = 4'b1111;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h000000D1;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 4'b0010 || bus.resp_data !== 32'h000000D1) begin errors++; $display("FAIL pp_resp: got %b %h expected 0010 000000d1", bus.resp_valid, bus.resp_data); end
        checks++; if (bus.req_ready !== 4'b0010 || bus.mem_req_addr !== 8'h31) begin errors++; $display("FAIL pp_grant: got %b %h expected 0010 31", bus.req_ready, bus.mem_req_addr); end
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL pp_outst: got %0d expected 4", outstanding); end
    endtask

    task automatic test_reset_inflight();
        @(posedge clk); #1;
        bus.req_valid      = 4'b0000;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h000000D2;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 4'b0100) begin errors++; $display("FAIL ri_resp: got %b expected 0100", bus.resp_valid); end
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL ri_outst3: got %0d expected 3", outstanding); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL ri_async: got %0d expected 0", outstanding); end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h000000EE;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 4'b0000 || protocol_error !== 1'b0) begin errors++; $display("FAIL ri_stray: got %b perr %b expected 0000 0", bus.resp_valid, protocol_error); end
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL ri_perr_set: got %b expected 1", protocol_error); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL ri_perr_sticky: got %b expected 1", protocol_error); end
    endtask

    task automatic test_mem_stall();
        do_reset();
        @(negedge clk);
        checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL stall_perr_clr: got %b expected 0", protocol_error); end
        bus.req_addr = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bus.req_valid     = 4'b1010;
            bus.mem_req_ready = 1'b0;
            @(negedge clk);
            checks++; if (bus.req_ready !== 4'b0000 || bus.mem_req_addr !== 8'h41) begin errors++; $display("FAIL stall_hold c%0d: got %b %h expected 0000 41", c, bus.req_ready, bus.mem_req_addr); end
        end
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL stall_first: got %b expected 0010", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b1000 || bus.mem_req_addr !== 8'h43) begin errors++; $display("FAIL stall_second: got %b %h expected 1000 43", bus.req_ready, bus.mem_req_addr); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL stall_outst: got %0d expected 2", outstanding); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall_full();
        test_full_push_pop();
        test_reset_inflight();
        test_mem_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
